// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - bus bundle between both cache controllers, the arbiter and main memory
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  // requester side: port 0 is the instruction cache, port 1 the data cache
  logic              req0_valid_i;
  logic              req0_rw_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [LINE_W-1:0] req0_data_i;
  logic              req1_valid_i;
  logic              req1_rw_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [LINE_W-1:0] req1_data_i;
  logic              rsp0_ready_o;
  logic              rsp1_ready_o;
  logic [LINE_W-1:0] rsp_data_o;

  // memory side
  logic              mem_valid_o;
  logic              mem_rw_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_ready_i;
  logic [LINE_W-1:0] mem_data_i;

  // the arbiter owns the memory port, so it is the master
  modport master (
    input  req0_valid_i, req0_rw_i, req0_addr_i, req0_data_i,
    input  req1_valid_i, req1_rw_i, req1_addr_i, req1_data_i,
    input  mem_ready_i, mem_data_i,
    output rsp0_ready_o, rsp1_ready_o, rsp_data_o,
    output mem_valid_o, mem_rw_o, mem_addr_o, mem_data_o
  );

  // requesters and memory model together form the slave side
  modport slave (
    output req0_valid_i, req0_rw_i, req0_addr_i, req0_data_i,
    output req1_valid_i, req1_rw_i, req1_addr_i, req1_data_i,
    output mem_ready_i, mem_data_i,
    input  rsp0_ready_o, rsp1_ready_o, rsp_data_o,
    input  mem_valid_o, mem_rw_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin arbiter sharing the memory port between icache and dcache
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic                clk_i,
  input  logic                rst_i,
  cache_mem_arbiter_if.master bus,
  output logic [31:0]         grant_cnt0_o,
  output logic [31:0]         grant_cnt1_o,
  output logic [31:0]         conflict_cnt_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT0 = 3'd1,
    GRANT1 = 3'd2,
    HOLD0  = 3'd3,
    HOLD1  = 3'd4
  } state_t;

  state_t      state_q;
  logic        last_q;
  logic [31:0] grant_cnt0_q;
  logic [31:0] grant_cnt1_q;
  logic [31:0] conflict_cnt_q;

  logic v0;
  logic v1;
  logic both_valid;
  logic any_valid;
  logic arb_winner;

  assign v0         = bus.req0_valid_i;
  assign v1         = bus.req1_valid_i;
  assign both_valid = v0 & v1;
  assign any_valid  = v0 | v1;
  // a lone requester wins outright; on a tie the port not served last wins
  assign arb_winner = both_valid ? ~last_q : v1;

  logic              mem_valid_d;
  logic              mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [LINE_W-1:0] mem_data_d;
  logic              rsp0_d;
  logic              rsp1_d;
  logic [LINE_W-1:0] rsp_data_d;

  // Route the granted port to memory; everything is quiet outside a grant state
  always_comb begin
    mem_valid_d = 1'b0;
    mem_rw_d    = 1'b0;
    mem_addr_d  = '0;
    mem_data_d  = '0;
    rsp0_d      = 1'b0;
    rsp1_d      = 1'b0;
    rsp_data_d  = '0;
    unique case (state_q)
      GRANT0: begin
        mem_valid_d = v0;
        mem_rw_d    = bus.req0_rw_i;
        mem_addr_d  = bus.req0_addr_i;
        mem_data_d  = bus.req0_data_i;
        // a completion arriving in the abort cycle is not reported
        rsp0_d      = bus.mem_ready_i & v0;
        rsp_data_d  = bus.mem_data_i;
      end
      GRANT1: begin
        mem_valid_d = v1;
        mem_rw_d    = bus.req1_rw_i;
        mem_addr_d  = bus.req1_addr_i;
        mem_data_d  = bus.req1_data_i;
        rsp1_d      = bus.mem_ready_i & v1;
        rsp_data_d  = bus.mem_data_i;
      end
      default: ;
    endcase
  end

  assign bus.mem_valid_o  = mem_valid_d;
  assign bus.mem_rw_o     = mem_rw_d;
  assign bus.mem_addr_o   = mem_addr_d;
  assign bus.mem_data_o   = mem_data_d;
  assign bus.rsp0_ready_o = rsp0_d;
  assign bus.rsp1_ready_o = rsp1_d;
  assign bus.rsp_data_o   = rsp_data_d;

  assign grant_cnt0_o   = grant_cnt0_q;
  assign grant_cnt1_o   = grant_cnt1_q;
  assign conflict_cnt_o = conflict_cnt_q;

  // Arbitration state machine with performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      grant_cnt0_q   <= '0;
      grant_cnt1_q   <= '0;
      conflict_cnt_q <= '0;
    end else if (state_q == GRANT0) begin
      if (!v0) begin
        state_q <= IDLE;
      end else if (bus.mem_ready_i) begin
        // a write-back is usually followed by an allocate; keep the port for it
        state_q <= bus.req0_rw_i ? HOLD0 : IDLE;
      end
    end else if (state_q == GRANT1) begin
      if (!v1) begin
        state_q <= IDLE;
      end else if (bus.mem_ready_i) begin
        state_q <= bus.req1_rw_i ? HOLD1 : IDLE;
      end
    end else if (state_q == HOLD0 && v0) begin
      // locked re-grant: counts as a grant but never as a conflict
      state_q      <= GRANT0;
      last_q       <= 1'b0;
      grant_cnt0_q <= grant_cnt0_q + 32'd1;
    end else if (state_q == HOLD1 && v1) begin
      state_q      <= GRANT1;
      last_q       <= 1'b1;
      grant_cnt1_q <= grant_cnt1_q + 32'd1;
    end else if (any_valid) begin
      // IDLE, or a hold whose owner did not come back
      state_q <= arb_winner ? GRANT1 : GRANT0;
      last_q  <= arb_winner;
      if (arb_winner) begin
        grant_cnt1_q <= grant_cnt1_q + 32'd1;
      end else begin
        grant_cnt0_q <= grant_cnt0_q + 32'd1;
      end
      if (both_valid) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
    end else begin
      state_q <= IDLE;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed and randomized checks of cache_mem_arbiter against a port-level model
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] grant_cnt0_o;
  logic [31:0] grant_cnt1_o;
  logic [31:0] conflict_cnt_o;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .bus            (bus.master),
    .grant_cnt0_o   (grant_cnt0_o),
    .grant_cnt1_o   (grant_cnt1_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // model: which port owns memory (-1 none), which port holds the lock (-1 none)
  int          owner;
  int          locked;
  int          prev;
  logic [31:0] m_cnt [2];
  logic [31:0] m_conf;
  logic        e_rsp [2];

  function automatic logic pv(input int p);
    return (p == 1) ? bus.req1_valid_i : bus.req0_valid_i;
  endfunction
  function automatic logic prw(input int p);
    return (p == 1) ? bus.req1_rw_i : bus.req0_rw_i;
  endfunction
  function automatic logic [31:0] paddr(input int p);
    return (p == 1) ? bus.req1_addr_i : bus.req0_addr_i;
  endfunction
  function automatic logic [127:0] pdata(input int p);
    return (p == 1) ? bus.req1_data_i : bus.req0_data_i;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic rw, input logic [31:0] a,
                         input logic [127:0] d);
    if (p == 1) begin
      bus.req1_valid_i = v; bus.req1_rw_i = rw; bus.req1_addr_i = a; bus.req1_data_i = d;
    end else begin
      bus.req0_valid_i = v; bus.req0_rw_i = rw; bus.req0_addr_i = a; bus.req0_data_i = d;
    end
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // compare every DUT output with what the model says for the current cycle
  task automatic settle();
    logic ev, erw;
    logic [31:0] ea;
    logic [127:0] ed, er;
    #1;
    ev = 1'b0; erw = 1'b0; ea = '0; ed = '0; er = '0;
    e_rsp[0] = 1'b0; e_rsp[1] = 1'b0;
    if (owner >= 0) begin
      ev  = pv(owner);
      erw = prw(owner);
      ea  = paddr(owner);
      ed  = pdata(owner);
      er  = bus.mem_data_i;
      e_rsp[owner] = bus.mem_ready_i & pv(owner);
    end
    chk("mem_valid", bus.mem_valid_o, ev);
    chk("mem_rw", bus.mem_rw_o, erw);
    chk("mem_addr", bus.mem_addr_o, ea);
    chk("mem_data", bus.mem_data_o, ed);
    chk("rsp0_ready", bus.rsp0_ready_o, e_rsp[0]);
    chk("rsp1_ready", bus.rsp1_ready_o, e_rsp[1]);
    chk("rsp_data", bus.rsp_data_o, er);
    chk("grant_cnt0", grant_cnt0_o, m_cnt[0]);
    chk("grant_cnt1", grant_cnt1_o, m_cnt[1]);
    chk("conflict_cnt", conflict_cnt_o, m_conf);
  endtask

  // apply the rules for the coming edge, then step the clock
  task automatic advance();
    if (rst_i) begin
      owner = -1; locked = -1; prev = 1;
      m_cnt = '{32'd0, 32'd0}; m_conf = 32'd0;
    end else if (owner >= 0) begin
      if (!pv(owner)) begin
        owner = -1;
      end else if (bus.mem_ready_i) begin
        locked = prw(owner) ? owner : -1;
        owner  = -1;
      end
    end else if (locked >= 0 && pv(locked)) begin
      owner = locked; prev = locked; m_cnt[locked]++; locked = -1;
    end else begin
      int cands[$];
      locked = -1;
      for (int p = 0; p < 2; p++) if (pv(p)) cands.push_back(p);
      if (cands.size() == 2) begin
        owner = 1 - prev; m_conf++;
      end else if (cands.size() == 1) begin
        owner = cands[0];
      end
      if (owner >= 0) begin
        prev = owner; m_cnt[owner]++;
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic rand_drive();
    for (int p = 0; p < 2; p++) begin
      if (pv(p)) begin
        if (e_rsp[p]) set_req(p, 1'($urandom % 2), 1'($urandom % 2), $urandom, rnd_line());
        else if ($urandom % 30 == 0) set_req(p, 1'b0, prw(p), paddr(p), pdata(p));
      end else if ($urandom % 3 == 0) begin
        set_req(p, 1'b1, 1'($urandom % 2), $urandom, rnd_line());
      end
    end
    bus.mem_ready_i = ($urandom % 3 == 0);
    bus.mem_data_i  = rnd_line();
    rst_i           = ($urandom % 250 == 0);
  endtask

  initial begin
    rst_i = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'd0, 128'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 128'd0);
    bus.mem_ready_i = 1'b0;
    bus.mem_data_i  = '0;
    owner = -1; locked = -1; prev = 1;
    m_cnt = '{32'd0, 32'd0}; m_conf = 32'd0;
    e_rsp = '{1'b0, 1'b0};
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // reset state
    settle();
    chk("reset_valid", bus.mem_valid_o, 1'b0);
    chk("reset_cnt0", grant_cnt0_o, 32'd0);
    chk("reset_conf", conflict_cnt_o, 32'd0);
    advance();

    // single fetch, memory answers three cycles after the request appears
    set_req(0, 1'b1, 1'b0, 32'h0000_1040, rnd_line());
    settle(); advance();
    settle();
    chk("fetch_valid", bus.mem_valid_o, 1'b1);
    chk("fetch_addr", bus.mem_addr_o, 32'h0000_1040);
    advance();
    settle(); advance();
    settle(); advance();
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = {4{32'hA5A5_A5A5}};
    settle();
    chk("fetch_rsp0", bus.rsp0_ready_o, 1'b1);
    chk("fetch_data", bus.rsp_data_o, {4{32'hA5A5_A5A5}});
    advance();
    bus.req0_valid_i = 1'b0; bus.mem_ready_i = 1'b0;
    settle();
    chk("fetch_cnt0", grant_cnt0_o, 32'd1);
    chk("fetch_idle", bus.mem_valid_o, 1'b0);
    advance();

    // simultaneous requests from reset alternate 0,1,0,1
    rst_i = 1'b1; settle(); advance(); rst_i = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0000_0100, rnd_line());
    set_req(1, 1'b1, 1'b0, 32'h0000_0200, rnd_line());
    bus.mem_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (i % 2 == 1) begin
        chk("rr_rsp0", bus.rsp0_ready_o, 1'(i % 4 == 1));
        chk("rr_rsp1", bus.rsp1_ready_o, 1'(i % 4 == 3));
      end
      advance();
    end
    bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0; bus.mem_ready_i = 1'b0;
    settle();
    chk("rr_conf", conflict_cnt_o, 32'd4);
    chk("rr_cnt0", grant_cnt0_o, 32'd2);
    chk("rr_cnt1", grant_cnt1_o, 32'd2);
    advance();

    // write-back lock: port 1 keeps the port for its allocate
    set_req(1, 1'b1, 1'b1, 32'h0000_2000, rnd_line());
    settle(); advance();
    bus.mem_ready_i = 1'b1;
    settle(); chk("wb_rsp1", bus.rsp1_ready_o, 1'b1); advance();
    set_req(1, 1'b1, 1'b0, 32'h0000_3000, rnd_line());
    set_req(0, 1'b1, 1'b0, 32'h0000_4000, rnd_line());
    settle();
    chk("hold_valid", bus.mem_valid_o, 1'b0);
    chk("hold_rsp1", bus.rsp1_ready_o, 1'b0);
    advance();
    settle();
    chk("lock_addr", bus.mem_addr_o, 32'h0000_3000);
    chk("lock_rsp1", bus.rsp1_ready_o, 1'b1);
    advance();
    bus.req1_valid_i = 1'b0;
    settle(); advance();
    settle();
    chk("lock_next_addr", bus.mem_addr_o, 32'h0000_4000);
    chk("lock_conf", conflict_cnt_o, 32'd4);
    chk("lock_cnt1", grant_cnt1_o, 32'd4);
    advance();
    bus.req0_valid_i = 1'b0; bus.mem_ready_i = 1'b0;

    // abort: valid drops in GRANT0, then stray completions
    set_req(0, 1'b1, 1'b0, 32'h0000_5000, rnd_line());
    settle(); advance();
    settle(); advance();
    bus.req0_valid_i = 1'b0; bus.mem_ready_i = 1'b1;
    settle(); chk("abort_rsp0", bus.rsp0_ready_o, 1'b0); advance();
    settle();
    chk("abort_idle_rsp0", bus.rsp0_ready_o, 1'b0);
    chk("abort_idle_valid", bus.mem_valid_o, 1'b0);
    chk("abort_cnt0", grant_cnt0_o, 32'd4);
    chk("abort_conf", conflict_cnt_o, 32'd4);
    advance();
    bus.mem_ready_i = 1'b0;

    // reset during GRANT1
    set_req(1, 1'b1, 1'b0, 32'h0000_6000, rnd_line());
    settle(); advance();
    rst_i = 1'b1;
    settle(); advance();
    rst_i = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0000_7000, rnd_line());
    settle();
    chk("rst_valid", bus.mem_valid_o, 1'b0);
    chk("rst_addr", bus.mem_addr_o, 32'd0);
    chk("rst_cnt1", grant_cnt1_o, 32'd0);
    chk("rst_conf", conflict_cnt_o, 32'd0);
    advance();
    bus.mem_ready_i = 1'b1;
    settle();
    chk("rst_tie_addr", bus.mem_addr_o, 32'h0000_7000);
    chk("rst_tie_rsp0", bus.rsp0_ready_o, 1'b1);
    advance();
    bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0; bus.mem_ready_i = 1'b0;
    settle(); advance();

    // counter wrap
    force dut.grant_cnt0_q = 32'hFFFF_FFFF;
    #1;
    release dut.grant_cnt0_q;
    m_cnt[0] = 32'hFFFF_FFFF;
    set_req(0, 1'b1, 1'b0, 32'h0000_8000, rnd_line());
    settle(); advance();
    bus.mem_ready_i = 1'b1;
    settle(); chk("wrap_cnt0", grant_cnt0_o, 32'd0); advance();
    bus.req0_valid_i = 1'b0; bus.mem_ready_i = 1'b0;
    settle(); advance();

    // randomized traffic, stray completions and occasional resets
    for (int n = 0; n < 3000; n++) begin
      settle();
      advance();
      rand_drive();
    end
    rst_i = 1'b0;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
